// File: rtl/serial_byte_feeder_pkg.sv
// Shared widths, FSM states and FIFO payload for the serial byte feeder.
package serial_feeder_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // One FIFO entry: the byte and the direction it is to be shifted in.
    typedef struct packed {
        logic              dir;
        logic [BYTE_W-1:0] data;
    } feed_entry_t;

    // First bit on the wire: MSB for left shift, LSB for right shift.
    function automatic logic first_bit(input logic [BYTE_W-1:0] data, input logic dir);
        return dir ? data[0] : data[BYTE_W-1];
    endfunction

endpackage

// File: rtl/serial_byte_feeder_byte_fifo.sv
// Small synchronous FIFO of byte/direction entries with registered level and flags.
module byte_fifo
    import serial_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  feed_entry_t              wr_data,
    input  logic                     rd_en,
    output feed_entry_t              rd_data_c,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    feed_entry_t        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level_d;
    logic               push_c;
    logic               pop_c;

    assign push_c    = wr_en && !full;
    assign pop_c     = rd_en && !empty;
    assign rd_data_c = mem[rd_ptr];

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_d = level;
        case ({push_c, pop_c})
            2'b10:   level_d = level + LVL_W'(1);
            2'b01:   level_d = level - LVL_W'(1);
            default: level_d = level;
        endcase
    end

    // Storage array; flushing is done by resetting the pointers, not the data.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level_d;
            full  <= (level_d == LVL_W'(DEPTH));
            empty <= (level_d == '0);
        end
    end

endmodule

// File: rtl/serial_byte_feeder.sv
// Serializes buffered bytes into an 8-bit direction-selectable shift register,
// ordering bits so the register's parallel output equals each accepted byte.
module serial_byte_feeder
    import serial_feeder_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BYTE_W-1:0]        s_data,
    input  logic                     s_dir,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic                     ser_in,
    output logic                     ser_dir,
    output logic                     busy,
    output logic                     word_valid,
    output logic [$clog2(DEPTH):0]   level
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);

    state_e              state_q;
    state_e              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [BYTE_W-1:0]   sreg_q;
    logic [BYTE_W-1:0]   sreg_d;
    logic                ser_in_d;
    logic                ser_dir_d;
    logic                busy_d;
    logic                word_valid_d;
    logic                pop_c;
    logic                push_c;
    logic                fifo_full;
    logic                fifo_empty;
    feed_entry_t         wr_entry;
    feed_entry_t         head_c;

    assign s_ready       = !fifo_full;
    assign push_c        = s_valid && s_ready;
    assign wr_entry.dir  = s_dir;
    assign wr_entry.data = s_data;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (push_c),
        .wr_data   (wr_entry),
        .rd_en     (pop_c),
        .rd_data_c (head_c),
        .level     (level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // State register plus the datapath and output registers it steers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sreg_q     <= '0;
            ser_in     <= IDLE_BIT;
            ser_dir    <= 1'b0;
            busy       <= 1'b0;
            word_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sreg_q     <= sreg_d;
            ser_in     <= ser_in_d;
            ser_dir    <= ser_dir_d;
            busy       <= busy_d;
            word_valid <= word_valid_d;
        end
    end

    // Next state: load a byte from the FIFO head or advance one bit per cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sreg_d       = sreg_q;
        ser_in_d     = ser_in;
        ser_dir_d    = ser_dir;
        word_valid_d = 1'b0;
        pop_c        = 1'b0;

        case (state_q)
            IDLE: begin
                ser_in_d = IDLE_BIT;
                if (!fifo_empty) begin
                    pop_c     = 1'b1;
                    sreg_d    = head_c.data;
                    ser_dir_d = head_c.dir;
                    ser_in_d  = first_bit(head_c.data, head_c.dir);
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                if (cnt_q == LAST_BIT) begin
                    // Eighth bit is on the wire: the byte lands downstream this edge.
                    word_valid_d = 1'b1;
                    if (!fifo_empty) begin
                        pop_c     = 1'b1;
                        sreg_d    = head_c.data;
                        ser_dir_d = head_c.dir;
                        ser_in_d  = first_bit(head_c.data, head_c.dir);
                        cnt_d     = '0;
                    end else begin
                        ser_in_d = IDLE_BIT;
                        state_d  = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (ser_dir) begin
                        // Right shift downstream: walk towards the MSB.
                        sreg_d   = sreg_q >> 1;
                        ser_in_d = sreg_q[1];
                    end else begin
                        // Left shift downstream: walk towards the LSB.
                        sreg_d   = sreg_q << 1;
                        ser_in_d = sreg_q[BYTE_W-2];
                    end
                end
            end

            default: begin
                ser_in_d = IDLE_BIT;
                state_d  = IDLE;
            end
        endcase

        busy_d = (state_d == SHIFT);
    end

endmodule

// File: tb/tb_serial_byte_feeder.sv
// Directed and random stimulus for serial_byte_feeder, checked against a
// schedule model: each accepted byte's bit window is derived from its accept cycle.
module tb_serial_byte_feeder;

    localparam int unsigned DEPTH    = 2;
    localparam logic        IDLE_BIT = 1'b0;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [7:0]             s_data;
    logic                   s_dir;
    logic                   s_valid;
    logic                   s_ready;
    logic                   ser_in;
    logic                   ser_dir;
    logic                   busy;
    logic                   word_valid;
    logic [$clog2(DEPTH):0] level;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic chk_en   = 1'b0;
    logic took     = 1'b0;

    // Model: accept cycle, first-bit cycle, data and direction of every byte since reset.
    int         q_acc[$];
    int         q_start[$];
    logic [7:0] q_data[$];
    logic       q_dir[$];

    // Downstream 8-bit shift register fed by the DUT.
    logic [7:0] sr;

    always #5 clk = ~clk;

    serial_byte_feeder #(
        .DEPTH    (DEPTH),
        .IDLE_BIT (IDLE_BIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_dir      (s_dir),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .ser_in     (ser_in),
        .ser_dir    (ser_dir),
        .busy       (busy),
        .word_valid (word_valid),
        .level      (level)
    );

    always @(posedge clk) begin
        sr <= ser_dir ? {ser_in, sr[7:1]} : {sr[6:0], ser_in};
    end

    // Bytes written before cycle t minus bytes already loaded by cycle t.
    function automatic int model_level(input int t);
        int n = 0;
        foreach (q_acc[i]) begin
            if (q_acc[i] < t)    n++;
            if (q_start[i] <= t) n--;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_cycle();
        int   t     = cyc;
        logic e_in  = IDLE_BIT;
        logic e_dir = 1'b0;
        logic e_bsy = 1'b0;
        logic e_wv  = 1'b0;
        int   wv_i  = -1;
        int   lvl;
        foreach (q_start[i]) begin
            if (q_start[i] <= t) e_dir = q_dir[i];
            if (t >= q_start[i] && t <= q_start[i] + 7) begin
                int k = t - q_start[i];
                e_bsy = 1'b1;
                e_in  = q_dir[i] ? q_data[i][k] : q_data[i][7-k];
            end
            if (q_start[i] + 8 == t) begin
                e_wv = 1'b1;
                wv_i = i;
            end
        end
        lvl = model_level(t);
        chk("ser_in",     ser_in,     e_in);
        chk("ser_dir",    ser_dir,    e_dir);
        chk("busy",       busy,       e_bsy);
        chk("word_valid", word_valid, e_wv);
        chk("level",      level,      8'(lvl));
        chk("s_ready",    s_ready,    8'(lvl < DEPTH));
        if (e_wv) chk("shreg_out", sr, q_data[wv_i]);
    endtask

    // One clock: update the model with this edge's handshake or reset, then check.
    task automatic tick();
        int st;
        @(posedge clk);
        took = 1'b0;
        if (!rst) begin
            q_acc.delete();
            q_start.delete();
            q_data.delete();
            q_dir.delete();
            chk_en = 1'b1;
        end else if (s_valid && (model_level(cyc) < int'(DEPTH))) begin
            st = cyc + 2;
            if (q_start.size() > 0 && q_start[$] + 8 > st) st = q_start[$] + 8;
            q_acc.push_back(cyc);
            q_start.push_back(st);
            q_data.push_back(s_data);
            q_dir.push_back(s_dir);
            took = 1'b1;
        end
        cyc++;
        #1;
        if (chk_en) check_cycle();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Hold valid until the byte is taken; returns right after the accepting edge.
    task automatic send(input logic [7:0] d, input logic dr);
        int guard = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_dir   = dr;
        tick();
        while (!took && guard < 64) begin
            tick();
            guard++;
        end
        chk("accept_bound", 8'(took), 8'd1);
        s_valid = 1'b0;
    endtask

    initial begin
        rst     = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_dir   = 1'b0;
        idle(3);
        rst = 1'b1;
        idle(2);

        // Single bytes, both directions.
        send(8'hA5, 1'b0);
        idle(12);
        send(8'h3C, 1'b1);
        idle(12);

        // Back-to-back with valid held; the fourth byte hits a full FIFO at a pop edge.
        send(8'h81, 1'b0);
        send(8'h0F, 1'b1);
        send(8'hF0, 1'b0);
        send(8'h5A, 1'b1);
        idle(40);

        // Reset after four bits of a byte.
        send(8'hFF, 1'b0);
        idle(4);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        idle(14);

        // Random bytes, directions and gaps.
        for (int n = 0; n < 40; n++) begin
            send(8'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 12));
        end
        idle(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
